regbank_access_arbiter: RTL and testbench
=========================================

// Module: regbank_access_arbiter
// PURPOSE
//  Sequences reads and writes of the 16-bit dual-output register bank for two requesters:
//  req0 is the processor control unit and req1 is the debug/load port.
//  Round-robin arbitration picks one requester. The block latches that request and drives
//  the bank's one-hot output enables (Oae/Obe) and load strobes (Ld).
//  It guarantees at most one register drives each tri-state bus, and only one Ld strobe is
//  active per operation. It also steers the write-data mux (DSel) to the granted requester.
// PARAMETERS
//  NREGS   16  number of registers in the bank (one Oae/Obe/Ld bit each)
//  AW       4  register address width; NREGS <= 2**AW
//  RD_CYC   1  cycles Oae/Obe are held in READ (>=1) so the downstream ALU can settle
// PORTS
//  Clk      in   1      clock; all state changes on posedge
//  Rst      in   1      reset, asynchronous, active-low (0 = reset)
//  V0,V1    in   1      request valid, req0/req1; must be held until that requester's Done
//  RA0,RA1  in   AW     read address, channel a
//  RB0,RB1  in   AW     read address, channel b
//  WE0,WE1  in   1      request includes a write
//  WA0,WA1  in   AW     write address
//  Gnt      out  2      one-hot grant pulse, 1 cycle, on acceptance
//  Done     out  2      one-hot completion pulse, 1 cycle
//  Oae      out  NREGS  one-hot (or zero) channel-a output enables
//  Obe      out  NREGS  one-hot (or zero) channel-b output enables
//  Ld       out  NREGS  one-hot (or zero) register load strobes
//  DSel     out  1      write-data mux select = owner index (0/1)
//  Busy     out  1      1 whenever state != IDLE
//  AErr     out  1      sticky: an address >= NREGS was seen; cleared only by reset
// BEHAVIOUR
//  - All outputs are registered. Rst=0 forces the following immediately, asynchronously:
//    * state=IDLE, all outputs 0, RR pointer=req0.
//    * Reset mid-operation aborts with no Ld pulse.
//  - FSM: IDLE -> READ -> (WRITE if latched WE) -> DONE -> IDLE.
//  - IDLE: if any V is high, arbitrate, latch RA/RB/WE/WA/owner, pulse Gnt[owner], enter READ.
//  - Arbitration when both V are high: grant the requester the RR pointer names. The pointer
//    then flips to the other requester. A single requester is granted regardless of pointer.
//  - READ: Oae=1<<RA and Obe=1<<RB for exactly RD_CYC cycles. RA==RB is legal: the same bit
//    is set in both buses.
//  - WRITE: Ld=1<<WA for exactly 1 cycle, with Oae/Obe=0 and DSel=owner.
//    * The write always follows the reads, so read-then-overwrite of one register is safe.
//  - DONE: Done[owner] pulses 1 cycle with enables 0; next cycle is IDLE and may arbitrate.
//  - Latency, V high in IDLE to Done: 1+RD_CYC+1 cycles without write, 2+RD_CYC+1 with write.
//    Minimum issue interval is the same plus 1 IDLE cycle.
//  - V dropping after Gnt is ignored; the operation completes.
//    Request inputs are sampled only in IDLE.
//  - Address >= NREGS: the matching enable or Ld bus stays all-zero for that phase, AErr sets,
//    and the sequence still completes with Done.
//  - DSel holds the last owner between operations; its reset value is 0.
// TESTING
//  1 Reset: Rst=0 mid-WRITE with Ld=0x0010 -> Ld, Oae, Obe, Gnt and Done = 0 immediately;
//    Busy=0; after release, state is IDLE.
//  2 V0 only: RA=3, RB=5, WE=1, WA=7, RD_CYC=1 -> Gnt=01 @c1; Oae=0x0008 and Obe=0x0020 @c2;
//    Ld=0x0080 and DSel=0 @c3; Done=01 @c4.
//  3 V0 and V1 together, both held: grants alternate 01, 10, 01. Each Done matches its Gnt,
//    and Oae/Obe/Ld never carry two owners at once.
//  4 V1 with WE=0, RA=RB=2 -> Oae=Obe=0x0004 for RD_CYC cycles; Ld stays 0; Done=10.
//  5 V0 with RA=9, WA=9, WE=1: Oae=0x0200 precedes Ld=0x0200 by >=1 cycle. V0 dropped at
//    READ: op still completes.
//  6 NREGS=12, WA=13 -> Ld stays 0, AErr=1 and stays set, Done still pulses.

Source files
------------

// File: rtl/regbank_access_arbiter.sv
// regbank_access_arbiter: round-robin sequencer driving one-hot read enables and load strobes of a register bank
module regbank_access_arbiter #(
  parameter int NREGS = 16,
  parameter int AW = 4,
  parameter int RD_CYC = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             V0,
  input  logic             V1,
  input  logic [AW-1:0]    RA0,
  input  logic [AW-1:0]    RA1,
  input  logic [AW-1:0]    RB0,
  input  logic [AW-1:0]    RB1,
  input  logic             WE0,
  input  logic             WE1,
  input  logic [AW-1:0]    WA0,
  input  logic [AW-1:0]    WA1,
  output logic [1:0]       Gnt,
  output logic [1:0]       Done,
  output logic [NREGS-1:0] Oae,
  output logic [NREGS-1:0] Obe,
  output logic [NREGS-1:0] Ld,
  output logic             DSel,
  output logic             Busy,
  output logic             AErr
);
  localparam int CW = (RD_CYC > 1) ? $clog2(RD_CYC) : 1;
  typedef enum logic [2:0] {st_idle, st_read, st_write, st_done, st_last} state_t;
  state_t state, state_nxt;
  logic ptr, own, we_q, acc, sel, aerr_nxt;
  logic [AW-1:0] ra_q, rb_q, wa_q;
  logic [CW-1:0] cnt;
  logic [1:0] gnt_nxt, done_nxt;
  logic [NREGS-1:0] oae_nxt, obe_nxt, ld_nxt;

  function automatic logic [NREGS-1:0] dec(input logic [AW-1:0] a);
    return (32'(a) < NREGS) ? NREGS'(1) << a : '0;
  endfunction

  function automatic logic bad(input logic [AW-1:0] a);
    return 32'(a) >= NREGS;
  endfunction

  assign acc = V0 | V1;
  assign sel = (V0 & V1) ? ptr : V1;

  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state <= st_idle;
      ptr <= 1'b0;
      own <= 1'b0;
      we_q <= 1'b0;
      ra_q <= '0;
      rb_q <= '0;
      wa_q <= '0;
      cnt <= '0;
      Gnt <= '0;
      Done <= '0;
      Oae <= '0;
      Obe <= '0;
      Ld <= '0;
      DSel <= 1'b0;
      Busy <= 1'b0;
      AErr <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= (state == st_read) ? cnt + 1'b1 : '0;
      if (state == st_idle && acc) begin
        own <= sel;
        DSel <= sel;
        ra_q <= sel ? RA1 : RA0;
        rb_q <= sel ? RB1 : RB0;
        wa_q <= sel ? WA1 : WA0;
        we_q <= sel ? WE1 : WE0;
        if (V0 & V1) ptr <= ~ptr;
      end
      Gnt <= gnt_nxt;
      Done <= done_nxt;
      Oae <= oae_nxt;
      Obe <= obe_nxt;
      Ld <= ld_nxt;
      Busy <= state_nxt != st_idle;
      AErr <= AErr | aerr_nxt;
    end

  // st_last covers the cycle Done is visible, so arbitration resumes one cycle later
  always_comb begin
    state_nxt = state;
    unique case (state)
      st_idle:  state_nxt = acc ? st_read : st_idle;
      st_read:  state_nxt = (cnt == CW'(RD_CYC - 1)) ? (we_q ? st_write : st_done) : st_read;
      st_write: state_nxt = st_done;
      st_done:  state_nxt = st_last;
      default:  state_nxt = st_idle;
    endcase
  end

  always_comb begin
    gnt_nxt = (state == st_idle && acc) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    oae_nxt = (state == st_read) ? dec(ra_q) : '0;
    obe_nxt = (state == st_read) ? dec(rb_q) : '0;
    ld_nxt = (state == st_write) ? dec(wa_q) : '0;
    done_nxt = (state == st_done) ? (own ? 2'b10 : 2'b01) : 2'b00;
    aerr_nxt = (state == st_read && (bad(ra_q) || bad(rb_q))) || (state == st_write && bad(wa_q));
  end
endmodule

// File: tb/tb_regbank_access_arbiter.sv
// tb_regbank_access_arbiter: directed and random checks of the register bank access arbiter
module tb_regbank_access_arbiter;
  localparam int NREGS = 12;
  localparam int AW = 4;
  localparam int RD = 1;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [1:0] v = '0;
  logic [1:0] we = '0;
  logic [AW-1:0] ra [2];
  logic [AW-1:0] rb [2];
  logic [AW-1:0] wa [2];
  logic [1:0] Gnt, Done;
  logic [NREGS-1:0] Oae, Obe, Ld;
  logic DSel, Busy, AErr;
  int checks = 0;
  int errors = 0;

  regbank_access_arbiter #(.NREGS(NREGS), .AW(AW), .RD_CYC(RD)) dut (
    .Clk(Clk), .Rst(Rst),
    .V0(v[0]), .V1(v[1]),
    .RA0(ra[0]), .RA1(ra[1]),
    .RB0(rb[0]), .RB1(rb[1]),
    .WE0(we[0]), .WE1(we[1]),
    .WA0(wa[0]), .WA1(wa[1]),
    .Gnt(Gnt), .Done(Done), .Oae(Oae), .Obe(Obe), .Ld(Ld),
    .DSel(DSel), .Busy(Busy), .AErr(AErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an operation is just an offset count from acceptance (1 = grant cycle)
  int m_off = 0;
  int m_L;
  int m_ra = 0, m_rb = 0, m_wa = 0;
  logic m_own = 0, m_ptr = 0, m_we = 0, m_dsel = 0, m_aerr = 0;
  logic m_sel;
  assign m_sel = (v == 2'b11) ? m_ptr : v[1];
  assign m_L = RD + 2 + (m_we ? 1 : 0);

  always @(posedge Clk or negedge Rst)
    if (!Rst) begin
      m_off <= 0;
      m_ptr <= 1'b0;
      m_dsel <= 1'b0;
      m_aerr <= 1'b0;
    end else if (m_off == 0) begin
      if (v != 2'b00) begin
        m_off <= 1;
        m_own <= m_sel;
        m_dsel <= m_sel;
        m_ra <= int'(ra[m_sel]);
        m_rb <= int'(rb[m_sel]);
        m_wa <= int'(wa[m_sel]);
        m_we <= we[m_sel];
        if (v == 2'b11) m_ptr <= !m_ptr;
      end
    end else begin
      m_off <= (m_off == m_L) ? 0 : m_off + 1;
      if (m_off == 1 && (m_ra >= NREGS || m_rb >= NREGS)) m_aerr <= 1'b1;
      if (m_we && m_off == RD + 1 && m_wa >= NREGS) m_aerr <= 1'b1;
    end

  always @(negedge Clk) begin
    chk("gnt", 32'(Gnt), (m_off == 1) ? (m_own ? 32'd2 : 32'd1) : 32'd0);
    chk("oae", 32'(Oae), (m_off >= 2 && m_off <= RD + 1 && m_ra < NREGS) ? 32'd1 << m_ra : 32'd0);
    chk("obe", 32'(Obe), (m_off >= 2 && m_off <= RD + 1 && m_rb < NREGS) ? 32'd1 << m_rb : 32'd0);
    chk("ld", 32'(Ld), (m_we && m_off == RD + 2 && m_wa < NREGS) ? 32'd1 << m_wa : 32'd0);
    chk("done", 32'(Done), (m_off != 0 && m_off == m_L) ? (m_own ? 32'd2 : 32'd1) : 32'd0);
    chk("busy", 32'(Busy), 32'(m_off != 0));
    chk("dsel", 32'(DSel), 32'(m_dsel));
    chk("aerr", 32'(AErr), 32'(m_aerr));
  end

  task automatic req(input int c, input int a, input int b, input int w, input int x);
    v[c] = 1'b1;
    ra[c] = AW'(a);
    rb[c] = AW'(b);
    we[c] = w[0];
    wa[c] = AW'(x);
  endtask

  task automatic rand_run(input int n, input int maxa);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      for (int c = 0; c < 2; c++) begin
        if (v[c] && m_off != 0 && int'(m_own) == c && (m_off == m_L || $urandom_range(7) == 0))
          v[c] = 1'b0;
        else if (!v[c] && !(m_off != 0 && int'(m_own) == c) && $urandom_range(2) == 0)
          req(c, int'($urandom_range(maxa)), int'($urandom_range(maxa)), int'($urandom_range(1)),
              int'($urandom_range(maxa)));
      end
    end
    v = '0;
    repeat (8) @(negedge Clk);
  endtask

  logic [1:0] gs [3];
  int ng;

  initial begin
    for (int c = 0; c < 2; c++) begin
      ra[c] = '0;
      rb[c] = '0;
      wa[c] = '0;
    end
    #1 Rst = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_oae", 32'(Oae), 0);
    chk("rst_gnt", 32'(Gnt), 0);
    chk("rst_dsel", 32'(DSel), 0);
    #2 Rst = 1'b1;
    @(negedge Clk);
    req(0, 3, 5, 1, 7);
    @(negedge Clk); chk("t2_gnt", 32'(Gnt), 32'h1);
    @(negedge Clk); chk("t2_oae", 32'(Oae), 32'h008); chk("t2_obe", 32'(Obe), 32'h020);
    @(negedge Clk); chk("t2_ld", 32'(Ld), 32'h080); chk("t2_dsel", 32'(DSel), 0);
    @(negedge Clk); chk("t2_done", 32'(Done), 32'h1); v[0] = 1'b0;
    repeat (2) @(negedge Clk);
    req(1, 2, 2, 0, 0);
    @(negedge Clk); chk("t4_gnt", 32'(Gnt), 32'h2);
    @(negedge Clk); chk("t4_oae", 32'(Oae), 32'h004); chk("t4_obe", 32'(Obe), 32'h004); chk("t4_ld", 32'(Ld), 0);
    @(negedge Clk); chk("t4_done", 32'(Done), 32'h2); chk("t4_ld2", 32'(Ld), 0); v[1] = 1'b0;
    repeat (2) @(negedge Clk);
    req(0, 9, 0, 1, 9);
    @(negedge Clk); chk("t5_gnt", 32'(Gnt), 32'h1); v[0] = 1'b0;
    @(negedge Clk); chk("t5_oae", 32'(Oae), 32'h200);
    @(negedge Clk); chk("t5_ld", 32'(Ld), 32'h200); chk("t5_oae_off", 32'(Oae), 0);
    @(negedge Clk); chk("t5_done", 32'(Done), 32'h1);
    repeat (2) @(negedge Clk);
    #2 Rst = 1'b0;
    @(negedge Clk);
    #2 Rst = 1'b1;
    @(negedge Clk);
    req(0, 1, 2, 0, 0);
    req(1, 6, 7, 0, 0);
    ng = 0;
    for (int i = 0; i < 40 && ng < 3; i++) begin
      @(negedge Clk);
      if (Gnt != 2'b00) begin
        gs[ng] = Gnt;
        ng++;
      end
    end
    v = '0;
    chk("t3_count", 32'(ng), 3);
    if (ng == 3) begin
      chk("t3_g0", 32'(gs[0]), 32'h1);
      chk("t3_g1", 32'(gs[1]), 32'h2);
      chk("t3_g2", 32'(gs[2]), 32'h1);
    end
    repeat (8) @(negedge Clk);
    rand_run(400, NREGS - 1);
    req(0, 0, 0, 1, 4);
    repeat (3) @(negedge Clk);
    chk("t1_ld_pre", 32'(Ld), 32'h010);
    #2 Rst = 1'b0;
    #1;
    chk("t1_ld", 32'(Ld), 0); chk("t1_oae", 32'(Oae), 0); chk("t1_obe", 32'(Obe), 0);
    chk("t1_gnt", 32'(Gnt), 0); chk("t1_done", 32'(Done), 0); chk("t1_busy", 32'(Busy), 0);
    v = '0;
    @(negedge Clk);
    #2 Rst = 1'b1;
    @(negedge Clk); chk("t1_idle", 32'(Busy), 0);
    req(1, 1, 1, 0, 0);
    @(negedge Clk); chk("t1_regnt", 32'(Gnt), 32'h2);
    @(negedge Clk);
    @(negedge Clk); chk("t1_redone", 32'(Done), 32'h2); v[1] = 1'b0;
    repeat (3) @(negedge Clk);
    req(1, 1, 2, 1, 13);
    @(negedge Clk);
    @(negedge Clk); chk("t6_aerr_pre", 32'(AErr), 0);
    @(negedge Clk); chk("t6_ld", 32'(Ld), 0); chk("t6_aerr", 32'(AErr), 1);
    @(negedge Clk); chk("t6_done", 32'(Done), 32'h2); v[1] = 1'b0;
    repeat (5) @(negedge Clk);
    chk("t6_sticky", 32'(AErr), 1);
    rand_run(400, 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
